// File: rtl/qid_free_list.sv
// qid_free_list: circular free list of queue-context IDs with in-use tracking.
// Grants one ID per cycle and rejects out-of-range or duplicate returns.
module qid_free_list #(
   parameter int MAX_QUEUES = 512,
   parameter int QID_WIDTH  = $clog2(MAX_QUEUES)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 alloc_req,
   output logic                 alloc_ack,
   output logic [QID_WIDTH-1:0] alloc_qid,
   input  logic                 free_req,
   input  logic [QID_WIDTH-1:0] free_qid,
   output logic                 init_done,
   output logic [QID_WIDTH:0]   free_count,
   output logic                 err_alloc_empty,
   output logic                 err_double_free,
   output logic                 err_bad_free
);
   typedef enum logic {INIT, READY} state_t;
   localparam logic [QID_WIDTH-1:0] LAST = QID_WIDTH'(MAX_QUEUES - 1);
   state_t state, state_nxt;
   logic [QID_WIDTH-1:0] fl [MAX_QUEUES];
   logic [MAX_QUEUES-1:0] in_use;
   logic [QID_WIDTH-1:0] head, tail, head_nxt, tail_nxt, head_qid;
   logic ready, last_init, grant, refuse, bad, accept, dbl, wr_en;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         state <= INIT;
      else
         state <= state_nxt;
   // Free checks use the pre-edge bitmap, so freeing the ID granted this cycle is a double free.
   always_comb begin
      ready     = state == READY;
      last_init = !ready && tail == LAST;
      state_nxt = last_init ? READY : state;
      grant     = ready && alloc_req && free_count != '0;
      refuse    = ready && alloc_req && free_count == '0;
      bad       = ready && free_req && {1'b0, free_qid} >= (QID_WIDTH+1)'(MAX_QUEUES);
      accept    = ready && free_req && !bad && in_use[free_qid];
      dbl       = free_req && !bad && !accept;
      head_qid  = fl[head];
      wr_en     = !ready || accept;
      head_nxt  = grant ? (head == LAST ? '0 : head + QID_WIDTH'(1)) : head;
      tail_nxt  = wr_en ? (tail == LAST ? '0 : tail + QID_WIDTH'(1)) : tail;
   end
   always_ff @(posedge clk)
      if (wr_en)
         fl[tail] <= ready ? free_qid : tail;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         head            <= '0;
         tail            <= '0;
         in_use          <= '0;
         free_count      <= '0;
         alloc_ack       <= 1'b0;
         alloc_qid       <= '0;
         init_done       <= 1'b0;
         err_alloc_empty <= 1'b0;
         err_double_free <= 1'b0;
         err_bad_free    <= 1'b0;
      end else begin
         head            <= head_nxt;
         tail            <= tail_nxt;
         free_count      <= free_count + (QID_WIDTH+1)'(wr_en) - (QID_WIDTH+1)'(grant);
         alloc_ack       <= grant;
         err_alloc_empty <= refuse;
         err_double_free <= dbl;
         err_bad_free    <= bad;
         if (grant) begin
            alloc_qid        <= head_qid;
            in_use[head_qid] <= 1'b1;
         end
         if (accept)
            in_use[free_qid] <= 1'b0;
         if (last_init)
            init_done <= 1'b1;
      end
endmodule

// File: tb/tb_qid_free_list.sv
// tb_qid_free_list: directed and random stimulus against a FIFO-queue model of the free list.
module tb_qid_free_list;
   localparam int MQ = 300;
   localparam int W  = $clog2(MQ);
   logic clk = 1'b0, reset_n = 1'b1, alloc_req = 1'b0, free_req = 1'b0;
   logic [W-1:0] free_qid = '0;
   logic alloc_ack, init_done, err_alloc_empty, err_double_free, err_bad_free;
   logic [W-1:0] alloc_qid;
   logic [W:0] free_count;
   int checks = 0, failures = 0;
   int fq[$];
   bit used [512];
   int icnt, gq, e_qid;
   bit e_ack, e_init, e_empty, e_dbl, e_bad, cmp_en = 1'b0;
   always #5 clk = ~clk;
   qid_free_list #(.MAX_QUEUES(MQ)) dut (
      .clk(clk), .reset_n(reset_n), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
      .alloc_qid(alloc_qid), .free_req(free_req), .free_qid(free_qid), .init_done(init_done),
      .free_count(free_count), .err_alloc_empty(err_alloc_empty),
      .err_double_free(err_double_free), .err_bad_free(err_bad_free)
   );
   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut=%0d exp=%0d", n, act, exp);
      end
   endtask
   task automatic model_reset();
      e_ack = 0; e_qid = 0; e_init = 0; e_empty = 0; e_dbl = 0; e_bad = 0; icnt = 0;
      fq.delete();
      foreach (used[i]) used[i] = 0;
   endtask
   // Free list is a plain FIFO; grant pops the front, accepted free pushes the back.
   task automatic model_update();
      e_ack = 0; e_empty = 0; e_dbl = 0; e_bad = 0; gq = -1;
      if (!e_init) begin
         e_dbl = free_req;
         fq.push_back(icnt);
         icnt++;
         e_init = (icnt == MQ);
      end else begin
         if (alloc_req) begin
            if (fq.size() == 0) e_empty = 1;
            else begin gq = fq.pop_front(); e_ack = 1; e_qid = gq; end
         end
         if (free_req) begin
            if (int'(free_qid) >= MQ) e_bad = 1;
            else if (!used[free_qid]) e_dbl = 1;
            else begin used[free_qid] = 0; fq.push_back(int'(free_qid)); end
         end
         if (gq >= 0) used[gq] = 1;
      end
   endtask
   task automatic step(input logic a, input logic f, input int q);
      alloc_req = a; free_req = f; free_qid = W'(q);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("alloc_ack", alloc_ack, e_ack);
         chk("alloc_qid", alloc_qid, e_qid);
         chk("init_done", init_done, e_init);
         chk("free_count", free_count, fq.size());
         chk("err_alloc_empty", err_alloc_empty, e_empty);
         chk("err_double_free", err_double_free, e_dbl);
         chk("err_bad_free", err_bad_free, e_bad);
      end
   end
   initial begin
      #1 reset_n = 1'b0;
      model_reset();
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < MQ; i++) begin
         step(1, 0, 0);
         if (i == MQ - 2) chk("init_low", init_done, 0);
      end
      chk("init_high", init_done, 1);
      chk("init_count", free_count, MQ);
      chk("init_noack", alloc_ack, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0);
         chk("first_grant", alloc_qid, i);
      end
      step(0, 1, 5);
      chk("dbl_free", err_double_free, 1);
      chk("dbl_count", free_count, MQ - 3);
      step(0, 1, 400);
      chk("bad_free", err_bad_free, 1);
      chk("bad_count", free_count, MQ - 3);
      repeat (MQ - 3) step(1, 0, 0);
      chk("drained", free_count, 0);
      step(1, 0, 0);
      chk("empty_err", err_alloc_empty, 1);
      chk("empty_noack", alloc_ack, 0);
      step(0, 1, 7);
      step(0, 1, 3);
      step(1, 0, 0);
      chk("reuse_7", alloc_qid, 7);
      step(1, 0, 0);
      chk("reuse_3", alloc_qid, 3);
      step(1, 1, 9);
      chk("simul_empty_err", err_alloc_empty, 1);
      chk("simul_empty_cnt", free_count, 1);
      step(1, 0, 0);
      chk("simul_reuse_9", alloc_qid, 9);
      for (int i = 20; i < 30; i++) step(0, 1, i);
      chk("cnt_10", free_count, 10);
      step(1, 1, 30);
      chk("simul_cnt_10", free_count, 10);
      chk("simul_grant_20", alloc_qid, 20);
      step(1, 1, 21);
      chk("same_id_dbl", err_double_free, 1);
      chk("same_id_grant", alloc_qid, 21);
      chk("same_id_cnt", free_count, 9);
      for (int i = 0; i < 2000; i++)
         step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
              ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, MQ - 1)) : int'($urandom_range(MQ, 511)));
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (MQ) step(0, 0, 0);
      repeat (20) step(1, 0, 0);
      chk("pre_rst_ack", alloc_ack, 1);
      chk("pre_rst_qid", alloc_qid, 19);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_ack", alloc_ack, 0);
      chk("rst_count", free_count, 0);
      chk("rst_init", init_done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (MQ) step(0, 0, 0);
      step(1, 0, 0);
      chk("reinit_grant", alloc_qid, 0);
      step(0, 1, 3);
      chk("reinit_dbl", err_double_free, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
